// File: rtl/cd101_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cd101_pkg
// Purpose  : Shared definitions for the envelope follower. Holds the gate FSM
//            state encodings, the default sample width and the shift-clamp
//            helper used by the slew stage.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cd101_pkg;

  // Default sample / envelope width in bits.
  localparam int W_DEFAULT = 8;

  // Width of the attack / release shift controls.
  localparam int SHIFT_W = 4;

  // Gate state machine encodings.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } gate_state_t;

  // Limit a shift amount to w-1 so a shift never exceeds the datapath width.
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s,
                                                     input int                 w);
    if (32'(s) > (w - 1)) begin
      return SHIFT_W'(w - 1);
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/env_slew.sv
`default_nettype none
// ============================================================================
// Module   : env_slew
// Purpose  : Combinational one-step envelope slew. Moves the envelope toward
//            the rectified sample by (difference >> shift), with a minimum
//            step of 1. The step never exceeds the difference, so the result
//            cannot overshoot the target or wrap.
// Ports    : rect     in  W  rectified (unsigned) sample
//            env      in  W  current envelope
//            ai       in  4  attack shift (already clamped)
//            ri       in  4  release shift (already clamped)
//            env_next out W  envelope after one step
// Revision : 1.0 - initial release
// ============================================================================
module env_slew
  import cd101_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0]       rect,
  input  logic [W-1:0]       env,
  input  logic [SHIFT_W-1:0] ai,
  input  logic [SHIFT_W-1:0] ri,
  output logic [W-1:0]       env_next
);

  logic               w_up;
  logic               w_down;
  logic [W-1:0]       w_diff;
  logic [SHIFT_W-1:0] w_shift;
  logic [W-1:0]       w_shifted;
  logic [W-1:0]       w_step;

  always_comb begin
    w_up      = (rect > env);
    w_down    = (rect < env);
    // Magnitude of the gap in whichever direction we are moving.
    w_diff    = w_up ? (rect - env) : (env - rect);
    w_shift   = w_up ? ai : ri;
    w_shifted = w_diff >> w_shift;
    // Minimum step of 1 guarantees convergence; when the gap is zero the
    // step is unused because neither direction is selected.
    w_step    = (w_shifted == '0) ? W'(1) : w_shifted;

    if (w_up) begin
      env_next = env + w_step;
    end else if (w_down) begin
      env_next = env - w_step;
    end else begin
      env_next = env;
    end
  end

endmodule
`default_nettype wire

// File: rtl/env_follower.sv
`default_nettype none
// ============================================================================
// Module   : env_follower
// Purpose  : Audio envelope follower with hysteretic note gate. Each valid
//            sample is rectified, the envelope slews toward it (attack /
//            release shifts), and a OFF/ON/HOLD gate FSM evaluates the new
//            envelope against on/off thresholds with a hold time.
// Ports    : clk          in  1  system clock, rising edge
//            rst_n        in  1  asynchronous active-low reset
//            sample_valid in  1  one-cycle strobe qualifying sample
//            sample       in  W  signed audio sample
//            ai           in  4  attack shift (clamped to W-1)
//            ri           in  4  release shift (clamped to W-1)
//            thr_on       in  W  gate-on threshold
//            thr_off      in  W  gate-off threshold (effective min(thr_off,thr_on))
//            hold         in  8  hold time in valid samples
//            envelope     out W  tracked envelope
//            env_valid    out 1  strobe when envelope updated
//            gate         out 1  high while a note is detected
//            trig_pulse   out 1  strobe on gate rising edge
//            peak         out W  (only with ENV_FOLLOWER_PEAK_EN) max envelope
//                                since the last trig_pulse
// Config   : define ENV_FOLLOWER_PEAK_EN to add the peak output and register.
// Revision : 1.0 - initial release
// ============================================================================
module env_follower
  import cd101_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic signed [W-1:0] sample,
  input  logic [3:0]          ai,
  input  logic [3:0]          ri,
  input  logic [W-1:0]        thr_on,
  input  logic [W-1:0]        thr_off,
  input  logic [7:0]          hold,
  output logic [W-1:0]        envelope,
  output logic                env_valid,
  output logic                gate,
  output logic                trig_pulse
`ifdef ENV_FOLLOWER_PEAK_EN
  ,
  output logic [W-1:0]        peak
`endif
);

  localparam logic [W-1:0] C_MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] C_POS_MAX  = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0]       w_sample_u;
  logic [W-1:0]       w_rect;
  logic [SHIFT_W-1:0] w_ai;
  logic [SHIFT_W-1:0] w_ri;
  logic [W-1:0]       w_env_next;
  logic [W-1:0]       w_thr_eff;

  gate_state_t        r_state;
  gate_state_t        w_state_next;
  logic [7:0]         r_hold_cnt;
  logic [7:0]         w_hold_next;
  logic               w_trig;

  // --------------------------------------------------------------------------
  // Rectifier: the most-negative code has no positive twin, so it saturates.
  // --------------------------------------------------------------------------
  assign w_sample_u = sample;

  always_comb begin
    if (!w_sample_u[W-1]) begin
      w_rect = w_sample_u;
    end else if (w_sample_u == C_MOST_NEG) begin
      w_rect = C_POS_MAX;
    end else begin
      w_rect = ~w_sample_u + W'(1);
    end
  end

  assign w_ai      = clamp_shift(ai, W);
  assign w_ri      = clamp_shift(ri, W);
  // Off threshold above the on threshold would make the gate chatter; cap it.
  assign w_thr_eff = (thr_off < thr_on) ? thr_off : thr_on;

  env_slew #(
    .W (W)
  ) u_env_slew (
    .rect     (w_rect),
    .env      (envelope),
    .ai       (w_ai),
    .ri       (w_ri),
    .env_next (w_env_next)
  );

  // --------------------------------------------------------------------------
  // Gate FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_OFF;
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
    end
  end

  // --------------------------------------------------------------------------
  // Gate FSM: next state, evaluated on the freshly computed envelope
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    w_trig       = 1'b0;

    if (sample_valid) begin
      case (r_state)
        ST_OFF: begin
          if (w_env_next >= thr_on) begin
            w_state_next = ST_ON;
            w_trig       = 1'b1;
          end
        end
        ST_ON: begin
          if (w_env_next < w_thr_eff) begin
            if (hold == 8'd0) begin
              w_state_next = ST_OFF;
            end else begin
              w_state_next = ST_HOLD;
              w_hold_next  = hold;
            end
          end
        end
        ST_HOLD: begin
          if (w_env_next >= thr_on) begin
            // Re-attack inside the hold window continues the same note.
            w_state_next = ST_ON;
            w_hold_next  = 8'd0;
          end else if (r_hold_cnt <= 8'd1) begin
            // The count covers the drop sample itself, so the last
            // decrement lands here and closes the gate.
            w_state_next = ST_OFF;
            w_hold_next  = 8'd0;
          end else begin
            w_hold_next  = r_hold_cnt - 8'd1;
          end
        end
        default: begin
          w_state_next = ST_OFF;
          w_hold_next  = 8'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      envelope   <= '0;
      env_valid  <= 1'b0;
      gate       <= 1'b0;
      trig_pulse <= 1'b0;
    end else begin
      env_valid  <= sample_valid;
      trig_pulse <= w_trig;
      gate       <= (w_state_next != ST_OFF);
      if (sample_valid) begin
        envelope <= w_env_next;
      end
    end
  end

`ifdef ENV_FOLLOWER_PEAK_EN
  // Peak restarts from the envelope that fired the trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (sample_valid) begin
      if (w_trig) begin
        peak <= w_env_next;
      end else if (w_env_next > peak) begin
        peak <= w_env_next;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_env_follower.sv
`default_nettype none
// ============================================================================
// Module   : tb_env_follower
// Purpose  : Directed, table-driven self-checking bench for env_follower
//            (default build, W=8). Each table row is one clock of stimulus
//            with the hand-computed registered outputs expected after it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_env_follower;

  localparam int W = 8;

  logic                clk;
  logic                rst_n;
  logic                sample_valid;
  logic signed [W-1:0] sample;
  logic [3:0]          ai;
  logic [3:0]          ri;
  logic [W-1:0]        thr_on;
  logic [W-1:0]        thr_off;
  logic [7:0]          hold;
  logic [W-1:0]        envelope;
  logic                env_valid;
  logic                gate;
  logic                trig_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          v;
    logic [W-1:0]  s;
    logic [3:0]    ai;
    logic [3:0]    ri;
    logic [W-1:0]  ton;
    logic [W-1:0]  toff;
    logic [7:0]    hld;
    logic [W-1:0]  e_env;
    logic          e_gate;
    logic          e_trig;
    logic          e_ev;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl [NVEC];

  env_follower #(
    .W (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .ai           (ai),
    .ri           (ri),
    .thr_on       (thr_on),
    .thr_off      (thr_off),
    .hold         (hold),
    .envelope     (envelope),
    .env_valid    (env_valid),
    .gate         (gate),
    .trig_pulse   (trig_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input int s, input int a, input int r,
                              input int ton, input int toff, input int hld,
                              input int e_env, input logic e_gate, input logic e_trig,
                              input logic e_ev);
    vec_t t;
    t.v      = v;
    t.s      = 8'(s);
    t.ai     = 4'(a);
    t.ri     = 4'(r);
    t.ton    = 8'(ton);
    t.toff   = 8'(toff);
    t.hld    = 8'(hld);
    t.e_env  = 8'(e_env);
    t.e_gate = e_gate;
    t.e_trig = e_trig;
    t.e_ev   = e_ev;
    return t;
  endfunction

  task automatic check(input string name, input logic [W-1:0] e_env, input logic e_gate,
                       input logic e_trig, input logic e_ev);
    checks++;
    if (envelope !== e_env || gate !== e_gate || trig_pulse !== e_trig || env_valid !== e_ev) begin
      errors++;
      $display("FAIL %s: got env=%0d gate=%b trig=%b env_valid=%b, expected env=%0d gate=%b trig=%b env_valid=%b",
               name, envelope, gate, trig_pulse, env_valid, e_env, e_gate, e_trig, e_ev);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    sample_valid = t.v;
    sample       = t.s;
    ai           = t.ai;
    ri           = t.ri;
    thr_on       = t.ton;
    thr_off      = t.toff;
    hold         = t.hld;
    @(posedge clk);
    #1;
    check($sformatf("vec%0d", idx), t.e_env, t.e_gate, t.e_trig, t.e_ev);
  endtask

  initial begin
    //            v  sample ai ri ton toff hld   env gate trig ev
    // Saturated most-negative input, instant attack, trigger
    tbl[0]  = mk(1, -128,  0, 0, 64,  32, 3,  127, 1, 0, 1);
    tbl[0].e_trig = 1'b1;
    tbl[1]  = mk(0, -128,  0, 0, 64,  32, 3,  127, 1, 0, 0);  // no valid: frozen
    tbl[2]  = mk(1, -128,  0, 0, 64,  32, 3,  127, 1, 0, 1);  // equal: unchanged
    tbl[3]  = mk(1,  100,  0, 0, 64,  32, 3,  100, 1, 0, 1);
    // Slow release: 100>>7 = 0, minimum step of 1
    tbl[4]  = mk(1,    0,  0, 7, 64,  32, 3,   99, 1, 0, 1);
    tbl[5]  = mk(1,    0,  0, 7, 64,  32, 3,   98, 1, 0, 1);
    tbl[6]  = mk(1,    0,  0, 7, 64,  32, 3,   97, 1, 0, 1);
    // Drop below thr_off: hold of 3 keeps gate high for 3 valids
    tbl[7]  = mk(1,   20,  0, 0, 64,  32, 3,   20, 1, 0, 1);
    tbl[8]  = mk(0,   20,  0, 0, 64,  32, 3,   20, 1, 0, 0);  // no valid: count frozen
    tbl[9]  = mk(1,   20,  0, 0, 64,  32, 3,   20, 1, 0, 1);
    tbl[10] = mk(1,   20,  0, 0, 64,  32, 3,   20, 1, 0, 1);
    tbl[11] = mk(1,   20,  0, 0, 64,  32, 3,   20, 0, 0, 1);
    // Fresh note, then re-attack to exactly thr_on inside hold: no trigger
    tbl[12] = mk(1,   70,  0, 0, 64,  32, 3,   70, 1, 1, 1);
    tbl[13] = mk(1,   20,  0, 0, 64,  32, 3,   20, 1, 0, 1);
    tbl[14] = mk(1,   20,  0, 0, 64,  32, 3,   20, 1, 0, 1);
    tbl[15] = mk(1,   64,  0, 0, 64,  32, 3,   64, 1, 0, 1);
    // hold = 0: ON straight to OFF
    tbl[16] = mk(1,   10,  0, 0, 64,  32, 0,   10, 0, 0, 1);
    tbl[17] = mk(1,    0,  0, 0, 64,  32, 0,    0, 0, 0, 1);
    // Attack shift 2 from 0 toward 100: 25, 43, 57, 67 (67 crosses thr_on)
    tbl[18] = mk(1,  100,  2, 0, 64,  32, 0,   25, 0, 0, 1);
    tbl[19] = mk(1,  100,  2, 0, 64,  32, 0,   43, 0, 0, 1);
    tbl[20] = mk(1,  100,  2, 0, 64,  32, 0,   57, 0, 0, 1);
    tbl[21] = mk(1,  100,  2, 0, 64,  32, 0,   67, 1, 1, 1);
    // thr_off above thr_on: effective off threshold is 64
    tbl[22] = mk(1,   66,  0, 0, 64, 200, 3,   66, 1, 0, 1);
    tbl[23] = mk(1,   63,  0, 0, 64, 200, 3,   63, 1, 0, 1);
    // After async reset mid-hold: starts from silence, fresh trigger
    tbl[24] = mk(1, -128,  0, 0, 64, 200, 3,  127, 1, 1, 1);
    // Shift 15 clamps to 7: 27>>7 = 0 and 1>>7 = 0 -> step of 1
    tbl[25] = mk(1, -100,  0, 15, 64, 200, 3, 126, 1, 0, 1);
    tbl[26] = mk(1,  127, 15, 0, 64, 200, 3,  127, 1, 0, 1);

    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    ai           = '0;
    ri           = '0;
    thr_on       = 8'd64;
    thr_off      = 8'd32;
    hold         = 8'd3;

    repeat (2) @(posedge clk);
    #1;
    check("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", 8'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i <= 23; i++) begin
      apply(tbl[i], i);
    end

    // Gate is in HOLD here; reset must clear outputs before the next edge.
    #3;
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("async_reset_mid_hold", 8'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;

    for (int i = 24; i < NVEC; i++) begin
      apply(tbl[i], i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
